// File: rtl/muldiv_seq.sv
// Sequential RV-M style multiply/divide unit: single-cycle multiply, restoring divider.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish at accept.
module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, DIV_RUN, FIXUP, DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_quo, r_rem, r_dvs, r_rs1, r_result;
    logic              r_neg_q, r_neg_r, r_dz, r_is_rem;

    logic              w_accept, w_is_mul, w_sa, w_sb, w_dsigned, w_dz;
    logic              w_rs1_neg, w_rs2_neg, w_early, w_ge;
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    logic [XLEN-1:0]   w_mul_res, w_abs1, w_abs2, w_early_res, w_sub, w_fix;
    logic [XLEN:0]     w_shift;

    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_is_mul  = ~op[2];

    // Sign/zero-extend both operands so one unsigned 2*XLEN multiply covers every variant
    assign w_sa      = (op == 3'd1) | (op == 3'd2);
    assign w_sb      = (op == 3'd1);
    assign w_mul_a   = {{XLEN{w_sa & rs1[XLEN-1]}}, rs1};
    assign w_mul_b   = {{XLEN{w_sb & rs2[XLEN-1]}}, rs2};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_mul_res = (op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_dsigned = ~op[0];
    assign w_rs1_neg = w_dsigned & rs1[XLEN-1];
    assign w_rs2_neg = w_dsigned & rs2[XLEN-1];
    assign w_abs1    = w_rs1_neg ? -rs1 : rs1;
    assign w_abs2    = w_rs2_neg ? -rs2 : rs2;
    assign w_dz      = (rs2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
    logic w_ovf;
    assign w_ovf       = w_dsigned & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
    assign w_early     = w_dz | w_ovf;
    assign w_early_res = w_dz ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    // Restoring step: shifted partial remainder never exceeds XLEN+1 bits
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    assign w_sub   = w_shift[XLEN-1:0] - r_dvs;

    always_comb begin
        w_fix = '0;
        if (r_dz)
            w_fix = r_is_rem ? r_rs1 : '1;
        else if (r_is_rem)
            w_fix = r_neg_r ? -r_rem : r_rem;
        else
            w_fix = r_neg_q ? -r_quo : r_quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_next = (w_is_mul | w_early) ? DONE : DIV_RUN;
                DIV_RUN: if (r_cnt == CW'(1)) w_next = FIXUP;
                FIXUP:   w_next = DONE;
                DONE:    if (out_ready) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == DONE);
    end

    assign result = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_rs1    <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (flush) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    if (w_is_mul) begin
                        r_result <= w_mul_res;
                    end else if (w_early) begin
                        r_result <= w_early_res;
                    end else begin
                        r_quo    <= w_abs1;
                        r_rem    <= '0;
                        r_dvs    <= w_abs2;
                        r_rs1    <= rs1;
                        r_cnt    <= CW'(XLEN);
                        r_neg_q  <= w_rs1_neg ^ w_rs2_neg;
                        r_neg_r  <= w_rs1_neg;
                        r_dz     <= w_dz;
                        r_is_rem <= op[1];
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                FIXUP:   r_result <= w_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq (XLEN=32) against an arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN for expected latency.
module tb_muldiv_seq;

    localparam int XLEN = 32;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rmode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        out_ready = (rmode == 2) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb2, ub, p;
        logic [63:0] up;
        logic        ovf;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: return a * b;
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Monitor: pops on each new out_valid, checks stability while stalled
    logic        hs_last = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_res = '0;
    always @(posedge clk) hs_last <= out_valid & out_ready;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end else if (hs_last) begin
                chk("valid_after_handshake", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("hold_result", result, prev_res);
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        prev_valid = rst_n & out_valid;
        prev_res   = result;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1 at cycle %0d", cyc);
            return;
        end
        in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
        if (track) sb.push_back('{ref_model(o, a, b), cyc + 1, exp_lat(o, a, b)});
        @(negedge clk);
        // Junk request while busy must be ignored
        in_valid = 1'b1; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b, held;
        int          n;

        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd5, 32'd100, 32'd0, 1'b1);
        issue(3'd7, 32'd100, 32'd0, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0, 1'b1);
        drain();

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 17); end
                3: b = 32'($signed(32'($urandom_range(0, 20))) - 10);
                default: ;
            endcase
            issue(3'($urandom_range(0, 7)), a, b, 1'b1);
        end
        drain();

        // Stall on out_ready: result and in_ready must hold
        rmode = 1;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_result", result, 32'hFFFF_FFFD);
            chk("stall_held", result, held);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rmode = 2;
        @(posedge clk);
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        rmode = 0;
        drain();

        // Flush mid-divide
        issue(3'd5, 32'd1000, 32'd7, 1'b0);
        repeat (8) @(negedge clk);
        chk("pre_flush_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-divide
        issue(3'd4, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        issue(3'd0, 32'd3, 32'd5, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
